vic_wb_buffer: RTL and testbench



---
 rtl/vic_wb_buffer.sv | 166 ++++++++++++++++
 tb/tb_vic_wb_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vic_wb_buffer.sv
// Writeback buffer behind the victim cache: queues dirty evictions and issues them to memory in FIFO order.
// Optional lookup forwarding CAM is enabled by defining VIC_WB_FWD_EN.
module vic_wb_buffer #(
  parameter  int unsigned NUM_WAYS = 4,
  parameter  int unsigned DEPTH    = 4,
  localparam int unsigned SET_BITS = $clog2(32 / NUM_WAYS),
  localparam int unsigned TAG_BITS = 13 - SET_BITS,
  localparam int unsigned VIC_W    = 64 + TAG_BITS + 2 + SET_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [VIC_W-1:0]    evicted_vic,
  input  logic                evicted_valid,
  output logic                wb_full,
  output logic [1:0]          wb_command,
  output logic [63:0]         wb_addr,
  output logic [63:0]         wb_data,
  input  logic [3:0]          mem_response,
  input  logic                lk_en,
  input  logic [SET_BITS-1:0] lk_idx,
  input  logic [TAG_BITS-1:0] lk_tag,
  output logic                lk_hit,
  output logic [63:0]         lk_data,
  output logic                wb_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [1:0]  BUS_NONE  = 2'b00;
  localparam logic [1:0]  BUS_STORE = 2'b10;

  typedef enum logic {ST_IDLE = 1'b0, ST_STORE = 1'b1} state_t;

  logic [63:0]         r_data [DEPTH];
  logic [TAG_BITS-1:0] r_tag  [DEPTH];
  logic [SET_BITS-1:0] r_idx  [DEPTH];
  logic [PW-1:0]       r_head;
  logic [PW-1:0]       r_tail;
  logic                r_wb_full;
  logic                r_overflow;
  state_t              r_state;
  state_t              w_state_nxt;

  logic [63:0]         w_in_data;
  logic [TAG_BITS-1:0] w_in_tag;
  logic [SET_BITS-1:0] w_in_idx;
  logic                w_in_valid;
  logic                w_in_dirty;
  logic [AW-1:0]       w_head_slot;
  logic [AW-1:0]       w_tail_slot;
  logic [PW-1:0]       w_head_nxt;
  logic [PW-1:0]       w_tail_nxt;
  logic                w_empty;
  logic                w_full_now;
  logic                w_full_nxt;
  logic                w_pop;
  logic                w_req;
  logic                w_enq;
  logic                w_drop;
  logic                w_lk_hit;
  logic [63:0]         w_lk_data;

  // Unpack the evicted line: {data, tag, valid, dirty, idx}
  assign w_in_idx   = evicted_vic[SET_BITS-1:0];
  assign w_in_dirty = evicted_vic[SET_BITS];
  assign w_in_valid = evicted_vic[SET_BITS+1];
  assign w_in_tag   = evicted_vic[SET_BITS+2 +: TAG_BITS];
  assign w_in_data  = evicted_vic[SET_BITS+2+TAG_BITS +: 64];

  assign w_head_slot = r_head[AW-1:0];
  assign w_tail_slot = r_tail[AW-1:0];
  assign w_empty     = (r_head == r_tail);
  assign w_full_now  = (r_head[AW-1:0] == r_tail[AW-1:0]) && (r_head[AW] != r_tail[AW]);

  // A pop in the same cycle frees a slot, so a full buffer can still accept
  assign w_pop  = (r_state == ST_STORE) && (mem_response != 4'd0);
  assign w_req  = evicted_valid & w_in_valid & w_in_dirty;
  assign w_enq  = w_req & (~w_full_now | w_pop);
  assign w_drop = w_req & w_full_now & ~w_pop;

  assign w_head_nxt = r_head + PW'(w_pop);
  assign w_tail_nxt = r_tail + PW'(w_enq);
  assign w_full_nxt = (w_head_nxt[AW-1:0] == w_tail_nxt[AW-1:0]) &&
                      (w_head_nxt[AW] != w_tail_nxt[AW]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_state_nxt = ST_STORE;
      ST_STORE: if (w_head_nxt == w_tail_nxt) w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_command = BUS_NONE;
    wb_addr    = '0;
    wb_data    = '0;
    if (r_state == ST_STORE) begin
      wb_command = BUS_STORE;
      wb_addr    = 64'({r_tag[w_head_slot], r_idx[w_head_slot], 3'b000});
      wb_data    = r_data[w_head_slot];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_wb_full  <= 1'b0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
        r_idx[i]  <= '0;
      end
    end else begin
      if (w_enq) begin
        r_data[w_tail_slot] <= w_in_data;
        r_tag[w_tail_slot]  <= w_in_tag;
        r_idx[w_tail_slot]  <= w_in_idx;
      end
      r_head    <= w_head_nxt;
      r_tail    <= w_tail_nxt;
      r_wb_full <= w_full_nxt;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

`ifdef VIC_WB_FWD_EN
  logic [PW-1:0] w_count;
  assign w_count = r_tail - r_head;

  // Scan oldest to youngest so the youngest match wins
  always_comb begin
    w_lk_hit  = 1'b0;
    w_lk_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (lk_en && (PW'(k) < w_count) &&
          (r_tag[AW'(r_head + PW'(k))] == lk_tag) &&
          (r_idx[AW'(r_head + PW'(k))] == lk_idx)) begin
        w_lk_hit  = 1'b1;
        w_lk_data = r_data[AW'(r_head + PW'(k))];
      end
    end
  end
`else
  logic w_unused_lk;
  assign w_unused_lk = ^{lk_en, lk_idx, lk_tag};
  assign w_lk_hit    = 1'b0;
  assign w_lk_data   = '0;
`endif

  assign lk_hit      = w_lk_hit;
  assign lk_data     = w_lk_data;
  assign wb_full     = r_wb_full;
  assign wb_overflow = r_overflow;

endmodule

// File: tb/tb_vic_wb_buffer.sv
// Directed bench for vic_wb_buffer at default parameters (3 set bits, 10 tag bits, depth 4).
module tb_vic_wb_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic [78:0] evicted_vic;
  logic        evicted_valid;
  logic        wb_full;
  logic [1:0]  wb_command;
  logic [63:0] wb_addr;
  logic [63:0] wb_data;
  logic [3:0]  mem_response;
  logic        lk_en;
  logic [2:0]  lk_idx;
  logic [9:0]  lk_tag;
  logic        lk_hit;
  logic [63:0] lk_data;
  logic        wb_overflow;

  int n_pass  = 0;
  int n_total = 0;

`ifdef VIC_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  vic_wb_buffer dut (
    .clock(clock), .reset(reset), .evicted_vic(evicted_vic), .evicted_valid(evicted_valid),
    .wb_full(wb_full), .wb_command(wb_command), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_response(mem_response), .lk_en(lk_en), .lk_idx(lk_idx), .lk_tag(lk_tag),
    .lk_hit(lk_hit), .lk_data(lk_data), .wb_overflow(wb_overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [78:0] mk(input logic v, input logic d, input logic [2:0] idx,
                                     input logic [9:0] tag, input logic [63:0] data);
    return {data, tag, v, d, idx};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; evicted_valid = 1'b0; evicted_vic = '0; mem_response = 4'd0;
    lk_en = 1'b1; lk_idx = 3'd0; lk_tag = 10'd0;
    tick(); tick();
    n_total++; if (wb_command !== 2'b00) $display("FAIL reset_cmd got=%0h exp=0", wb_command); else n_pass++;
    n_total++; if (wb_addr !== 64'd0) $display("FAIL reset_addr got=%0h exp=0", wb_addr); else n_pass++;
    n_total++; if (wb_data !== 64'd0) $display("FAIL reset_data got=%0h exp=0", wb_data); else n_pass++;
    n_total++; if (wb_full !== 1'b0) $display("FAIL reset_full got=%0b exp=0", wb_full); else n_pass++;
    n_total++; if (lk_hit !== 1'b0) $display("FAIL reset_lk_hit got=%0b exp=0", lk_hit); else n_pass++;
    n_total++; if (lk_data !== 64'd0) $display("FAIL reset_lk_data got=%0h exp=0", lk_data); else n_pass++;
    n_total++; if (wb_overflow !== 1'b0) $display("FAIL reset_ovf got=%0b exp=0", wb_overflow); else n_pass++;
    reset = 1'b0; lk_en = 1'b0;
    tick();
  endtask

  task automatic test_single_store();
    evicted_vic = mk(1'b1, 1'b1, 3'd3, 10'h055, 64'hDEAD); evicted_valid = 1'b1; mem_response = 4'd0;
    tick();
    evicted_valid = 1'b0;
    n_total++; if (wb_command !== 2'b00) $display("FAIL single_not_yet got=%0h exp=0", wb_command); else n_pass++;
    lk_en = 1'b1; lk_idx = 3'd3; lk_tag = 10'h055;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) mem_response = 4'd1;
      n_total++; if (wb_command !== 2'b10) $display("FAIL single_cmd_c%0d got=%0h exp=2", c, wb_command); else n_pass++;
      n_total++; if (wb_addr !== 64'h1558) $display("FAIL single_addr_c%0d got=%0h exp=1558", c, wb_addr); else n_pass++;
      n_total++; if (wb_data !== 64'hDEAD) $display("FAIL single_data_c%0d got=%0h exp=dead", c, wb_data); else n_pass++;
    end
    n_total++; if (lk_hit !== FWD) $display("FAIL single_lk_hit got=%0b exp=%0b", lk_hit, FWD); else n_pass++;
    n_total++; if (lk_data !== (FWD ? 64'hDEAD : 64'd0)) $display("FAIL single_lk_data got=%0h", lk_data); else n_pass++;
    tick();
    mem_response = 4'd0; lk_en = 1'b0;
    n_total++; if (wb_command !== 2'b00) $display("FAIL single_done got=%0h exp=0", wb_command); else n_pass++;
    n_total++; if (wb_addr !== 64'd0) $display("FAIL single_done_addr got=%0h exp=0", wb_addr); else n_pass++;
  endtask

  task automatic test_full_overflow();
    mem_response = 4'd0;
    for (int i = 0; i < 4; i++) begin
      evicted_vic = mk(1'b1, 1'b1, 3'(i), 10'(i + 1), 64'h100 + 64'(i)); evicted_valid = 1'b1;
      tick();
      n_total++;
      if (wb_full !== (i == 3)) $display("FAIL full_after_%0d got=%0b exp=%0b", i + 1, wb_full, (i == 3));
      else n_pass++;
    end
    n_total++; if (wb_overflow !== 1'b0) $display("FAIL ovf_early got=%0b exp=0", wb_overflow); else n_pass++;
    evicted_vic = mk(1'b1, 1'b1, 3'd7, 10'h3F0, 64'h1FF);
    tick();
    evicted_valid = 1'b0;
    n_total++; if (wb_overflow !== 1'b1) $display("FAIL ovf_set got=%0b exp=1", wb_overflow); else n_pass++;
    n_total++; if (wb_full !== 1'b1) $display("FAIL ovf_full got=%0b exp=1", wb_full); else n_pass++;
    n_total++; if (wb_data !== 64'h100) $display("FAIL ovf_head got=%0h exp=100", wb_data); else n_pass++;
  endtask

  task automatic test_full_accept();
    logic [63:0] exp_data [4];
    logic        exp_full [4];
    exp_data[0] = 64'h101; exp_data[1] = 64'h102; exp_data[2] = 64'h103; exp_data[3] = 64'h105;
    exp_full[0] = 1'b1;    exp_full[1] = 1'b0;    exp_full[2] = 1'b0;    exp_full[3] = 1'b0;
    evicted_vic = mk(1'b1, 1'b1, 3'd5, 10'd5, 64'h105); evicted_valid = 1'b1; mem_response = 4'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      evicted_valid = 1'b0;
      n_total++; if (wb_data !== exp_data[i]) $display("FAIL accept_data_%0d got=%0h exp=%0h", i, wb_data, exp_data[i]); else n_pass++;
      n_total++; if (wb_full !== exp_full[i]) $display("FAIL accept_full_%0d got=%0b exp=%0b", i, wb_full, exp_full[i]); else n_pass++;
    end
    n_total++; if (wb_addr !== 64'h168) $display("FAIL accept_addr_last got=%0h exp=168", wb_addr); else n_pass++;
    tick();
    mem_response = 4'd0;
    n_total++; if (wb_command !== 2'b00) $display("FAIL accept_drained got=%0h exp=0", wb_command); else n_pass++;
    n_total++; if (wb_overflow !== 1'b1) $display("FAIL ovf_sticky got=%0b exp=1", wb_overflow); else n_pass++;
  endtask

  task automatic test_clean_discard();
    evicted_valid = 1'b1; evicted_vic = mk(1'b1, 1'b0, 3'd2, 10'h011, 64'hAAAA);
    tick();
    evicted_vic = mk(1'b0, 1'b1, 3'd2, 10'h011, 64'hBBBB);
    tick();
    evicted_valid = 1'b0; evicted_vic = mk(1'b1, 1'b1, 3'd2, 10'h011, 64'hCCCC);
    tick(); tick();
    n_total++; if (wb_command !== 2'b00) $display("FAIL clean_cmd got=%0h exp=0", wb_command); else n_pass++;
    n_total++; if (wb_full !== 1'b0) $display("FAIL clean_full got=%0b exp=0", wb_full); else n_pass++;
  endtask

  task automatic test_forwarding();
    mem_response = 4'd0; lk_en = 1'b1; lk_idx = 3'd5; lk_tag = 10'h2AA;
    evicted_vic = mk(1'b1, 1'b1, 3'd5, 10'h2AA, 64'h1); evicted_valid = 1'b1;
    #1;
    n_total++; if (lk_hit !== 1'b0) $display("FAIL fwd_enq_same_cycle got=%0b exp=0", lk_hit); else n_pass++;
    tick();
    evicted_vic = mk(1'b1, 1'b1, 3'd5, 10'h2AA, 64'h2);
    #1;
    n_total++; if (lk_data !== (FWD ? 64'h1 : 64'h0)) $display("FAIL fwd_one_entry got=%0h", lk_data); else n_pass++;
    tick();
    evicted_valid = 1'b0;
    n_total++; if (lk_hit !== FWD) $display("FAIL fwd_hit got=%0b exp=%0b", lk_hit, FWD); else n_pass++;
    n_total++; if (lk_data !== (FWD ? 64'h2 : 64'h0)) $display("FAIL fwd_youngest got=%0h", lk_data); else n_pass++;
    lk_tag = 10'h2AB;
    #1;
    n_total++; if (lk_hit !== 1'b0) $display("FAIL fwd_tag_miss got=%0b exp=0", lk_hit); else n_pass++;
    lk_tag = 10'h2AA; mem_response = 4'd1;
    tick();
    n_total++; if (wb_data !== 64'h2) $display("FAIL fwd_second_store got=%0h exp=2", wb_data); else n_pass++;
    n_total++; if (lk_data !== (FWD ? 64'h2 : 64'h0)) $display("FAIL fwd_popping_entry got=%0h", lk_data); else n_pass++;
    tick();
    mem_response = 4'd0;
    n_total++; if (lk_hit !== 1'b0) $display("FAIL fwd_drained got=%0b exp=0", lk_hit); else n_pass++;
    n_total++; if (wb_command !== 2'b00) $display("FAIL fwd_idle got=%0h exp=0", wb_command); else n_pass++;
    lk_en = 1'b0;
  endtask

  task automatic test_reset_mid_store();
    mem_response = 4'd0;
    for (int i = 0; i < 3; i++) begin
      evicted_vic = mk(1'b1, 1'b1, 3'(i), 10'h100 + 10'(i), 64'h700 + 64'(i)); evicted_valid = 1'b1;
      tick();
    end
    evicted_valid = 1'b0;
    n_total++; if (wb_command !== 2'b10) $display("FAIL mid_store_busy got=%0h exp=2", wb_command); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++; if (wb_command !== 2'b00) $display("FAIL mid_reset_cmd got=%0h exp=0", wb_command); else n_pass++;
    n_total++; if (wb_full !== 1'b0) $display("FAIL mid_reset_full got=%0b exp=0", wb_full); else n_pass++;
    n_total++; if (wb_overflow !== 1'b0) $display("FAIL mid_reset_ovf got=%0b exp=0", wb_overflow); else n_pass++;
    #2 reset = 1'b0;
    tick();
    evicted_vic = mk(1'b1, 1'b1, 3'd1, 10'h3FF, 64'hCAFE); evicted_valid = 1'b1;
    tick();
    evicted_valid = 1'b0;
    tick();
    n_total++; if (wb_addr !== 64'hFFC8) $display("FAIL fresh_addr got=%0h exp=ffc8", wb_addr); else n_pass++;
    n_total++; if (wb_data !== 64'hCAFE) $display("FAIL fresh_data got=%0h exp=cafe", wb_data); else n_pass++;
    mem_response = 4'd8;
    tick();
    mem_response = 4'd0;
    n_total++; if (wb_command !== 2'b00) $display("FAIL fresh_done got=%0h exp=0", wb_command); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_full_overflow();
    test_full_accept();
    test_clean_discard();
    test_forwarding();
    test_reset_mid_store();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
